// File: rtl/btn_led_pkg.sv
// Shared constants for the button/LED debounce block: mode encoding, default
// debounce length, heartbeat width and the debounce counter width helper.
package btn_led_pkg;

    localparam logic MODE_FOLLOW = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    // 10 ms at 25 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 250000;

    localparam int HB_W = 24;

    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_led_debounce_if.sv
// Button/LED bundle between the board top level and the debounce block.
// The master side drives buttons and modes; the slave side drives the LEDs.
interface btn_led_debounce_if #(
    parameter int N_BTN = 7,
    parameter int N_LED = 8
);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] mode;
    logic [N_LED-1:0] led;
    logic [N_BTN-1:0] btn_press;
    logic             wifi_gpio0;

    modport master (
        output btn, mode,
        input  led, btn_press, wifi_gpio0
    );

    modport slave (
        input  btn, mode,
        output led, btn_press, wifi_gpio0
    );
endinterface

// File: rtl/btn_debounce_chan.sv
// One button channel: polarity fix, 2-flop synchroniser, debounce counter,
// debounced level, one-cycle press pulse and the toggle-mode LED state.
module btn_debounce_chan
    import btn_led_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic INV             = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_mode,
    output logic o_stable,
    output logic o_tog,
    output logic o_press
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_raw;
    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_press;
    logic             r_tog;
    logic [CNT_W-1:0] r_cnt;

    assign w_raw = i_btn ^ INV;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_tog    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_press <= 1'b0;

            // Any sample matching the accepted level discards accumulated credit.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
                r_press  <= r_s2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (i_mode == MODE_FOLLOW) begin
                r_tog <= 1'b0;
            end else if (r_press) begin
                r_tog <= ~r_tog;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_tog    = r_tog;
    assign o_press  = r_press;

endmodule

// File: rtl/btn_led_debounce.sv
// ULX3S button-to-LED block: N_BTN debounced channels, follow/toggle LED mux,
// spare LEDs and the ESP32 GPIO0 strap. Define BTN_LED_HEARTBEAT_EN for a heartbeat on led[N_LED-1].
module btn_led_debounce
    import btn_led_pkg::*;
#(
    parameter int               N_BTN           = 7,
    parameter int               N_LED           = 8,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [N_BTN-1:0] BTN_INV         = 7'b0000001,
    parameter int               HB_WIDTH        = HB_W
) (
    input  logic                clk_25mhz,
    input  logic                rst,
    btn_led_debounce_if.slave   bus
);

    generate
        if (N_BTN < 1 || N_LED < N_BTN || DEBOUNCE_CYCLES < 2 || HB_WIDTH < 2) begin : g_param_err
            $error("btn_led_debounce: illegal parameter combination");
        end
    endgenerate

    logic [N_BTN-1:0] w_stable;
    logic [N_BTN-1:0] w_tog;
    logic [N_BTN-1:0] w_press;
    logic [N_LED-1:0] w_led;

    generate
        for (genvar g = 0; g < N_BTN; g++) begin : g_chan
            btn_debounce_chan #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INV             (BTN_INV[g])
            ) u_chan (
                .clk      (clk_25mhz),
                .rst      (rst),
                .i_btn    (bus.btn[g]),
                .i_mode   (bus.mode[g]),
                .o_stable (w_stable[g]),
                .o_tog    (w_tog[g]),
                .o_press  (w_press[g])
            );
        end
    endgenerate

`ifdef BTN_LED_HEARTBEAT_EN
    generate
        if (N_LED <= N_BTN) begin : g_hb_err
            $error("btn_led_debounce: heartbeat needs a spare LED (N_LED > N_BTN)");
        end
    endgenerate

    logic [HB_WIDTH-1:0] r_hb;

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            r_hb <= '0;
        end else begin
            r_hb <= r_hb + HB_WIDTH'(1);
        end
    end
`endif

    always_comb begin
        w_led = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_led[i] = (bus.mode[i] == MODE_TOGGLE) ? w_tog[i] : w_stable[i];
        end
`ifdef BTN_LED_HEARTBEAT_EN
        w_led[N_LED-1] = r_hb[HB_WIDTH-1];
`endif
    end

    assign bus.led        = w_led;
    assign bus.btn_press  = w_press;
    // Strap stays high even in reset so the ESP32 never sees a reset request.
    assign bus.wifi_gpio0 = 1'b1;

endmodule

// File: doc/btn_led_debounce.md
Name: btn_led_debounce

Overview:
- Parametrised successor to the board's button→LED passthrough for the ULX3S top level.
- Per channel: synchronises each raw button, debounces it, and drives the matching LED.
- Each LED is driven in one of two modes: follow (LED = debounced level) or toggle (LED flips on each debounced press).
- Also emits one-cycle press pulses for downstream logic and holds the WiFi GPIO0 strap high.

Parameters:
- N_BTN, 7, number of button channels (≥1).
- N_LED, 8, number of LEDs (≥N_BTN); LEDs above N_BTN-1 are spare.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); ≥2.
- BTN_INV, 7'b0000001, per-channel polarity mask; 1 = button is active-low (btn[0] PWR on ULX3S).

Ports:
- clk_25mhz  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn  in  N_BTN  raw asynchronous buttons.
- mode  in  N_BTN  per-channel mode, synchronous to clk_25mhz; 0 = follow, 1 = toggle.
- led  out  N_LED  LED drive.
- btn_press  out  N_BTN  one-cycle pulse per debounced press.
- wifi_gpio0  out  1  tied 1 (prevents ESP32 reset), including during rst.

Behaviour:
- Normalise: raw[i] = btn[i] XOR BTN_INV[i], so 1 always means pressed.
- Synchroniser: 2-flop per channel; s2[i] reflects raw[i] 2 edges later. Reset value 0.
- Debounce counter, per channel, width $clog2(DEBOUNCE_CYCLES):
  - s2 == stable: counter ← 0.
  - s2 != stable and counter < DEBOUNCE_CYCLES-1: counter++.
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable ← s2, counter ← 0.
  - Any glitch back to the stable value clears the counter (no partial credit). The counter never wraps.
- Latency: a clean raw edge at edge k gives a stable change at edge k+2+DEBOUNCE_CYCLES.
- btn_press[i]: registered; high exactly in the cycle stable[i] first reads 1. No pulse on release. Reset value 0.
- Toggle register tog[i]:
  - Flips in the cycle after btn_press[i].
  - Held at 0 while mode[i] = 0, so every entry into toggle mode starts with the LED off.
- led[i], i < N_BTN: mode[i] ? tog[i] : stable[i]. Combinational from registers only.
- led[i], i ≥ N_BTN: 0 (see optional feature).
- Mode change mid-press: takes effect the next cycle; no press pulse is generated or suppressed by a mode change.
- Reset:
  - Synchronous; clears synchronisers, counters, stable, tog and btn_press.
  - LEDs read 0 in the cycle after rst is sampled high.
  - A button held through reset is re-debounced from 0 and produces one press pulse after release of reset.
- Simultaneous presses on several channels: fully independent; pulses may coincide.

Optional Feature:
- BTN_LED_HEARTBEAT_EN defined:
  - led[N_LED-1] blinks as a heartbeat, driven from the MSB of a free-running 24-bit counter (~1.5 Hz at 25 MHz). Counter reset value 0.
  - Requires N_LED > N_BTN; otherwise elaboration error.
- Undefined: led[N_LED-1] follows the spare rule (0), and no heartbeat counter exists.

Decomposition:
- Package btn_led_pkg:
  - MODE_FOLLOW / MODE_TOGGLE constants.
  - Default DEBOUNCE_CYCLES.
  - HB_W = 24.
  - Function for counter width.
- Sub-module btn_debounce_chan: one channel (synchroniser, counter, stable, press pulse, toggle).
- Top instantiates N_BTN copies with a generate loop and adds the LED mux, spare LEDs and heartbeat.

Test Plan:
- Reset: rst=1 for 3 cycles with all btn pressed → led=0, btn_press=0, wifi_gpio0=1 throughout.
- Follow latency (DEBOUNCE_CYCLES=4, BTN_INV=0): btn[2] 0→1 at edge 10 → led[2]=1 and btn_press[2]=1 at edge 16; pulse low at edge 17; release → led[2]=0 at edge +6, no pulse.
- Bounce: btn[1] pattern 1,0,1,0 on alternating cycles, then held 1 → led[1] rises exactly 6 cycles after the final 0→1; exactly one btn_press[1].
- Toggle: mode[3]=1; three clean presses → led[3] goes 1,0,1, each one cycle after its btn_press[3]; set mode[3]=0 → led[3] follows level, tog cleared; re-enter toggle → led[3]=0.
- Polarity: BTN_INV[0]=1, btn[0] held 1 → led[0]=0; drive btn[0]=0 → led[0]=1 after 6 cycles.
- Heartbeat (macro defined, HB_W shortened in bench to 4): led[7] toggles every 8 cycles after reset; macro undefined → led[7]=0 constant.
